uart_txrx: RTL and testbench

- Byte-wide 8N1 UART transmitter and receiver pair sharing one clock and reset. The two halves are independent.
- The transmitter serialises one byte per enable handshake.
- The receiver deserialises frames arriving on its serial pin and flags each received byte with a one-cycle strobe.
- The block sits between the board serial pins and the byte-level control logic. It is run in loopback (Tx_Pin_Out to Rx_Pin_In) for verification.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_timer.sv | 32 +++
 rtl/uart_txrx.sv | 163 ++++++++++++++++
 tb/tb_uart_txrx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART pair: data width, bit-time helper and
// the state set used by both the transmit and receive FSMs.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      DONE
   } uart_state_t;

   function automatic int calc_bit_clks(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: clears on clr, advances while en, and flags the last
// clock of a bit period (tick_full) and the middle of it (tick_half).
module uart_bit_timer #(
   parameter int BIT_CLKS = 16
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic en,
   output logic tick_full,
   output logic tick_half
);

   localparam int            CW   = $clog2(BIT_CLKS);
   localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);
   localparam logic [CW-1:0] HALF = CW'(BIT_CLKS / 2 - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
   end

   assign tick_full = en && (cnt == LAST);
   assign tick_half = en && (cnt == HALF);

endmodule

// File: rtl/uart_txrx.sv
// Independent 8N1 UART transmitter and receiver sharing CLK/RST; each half
// is a two-process FSM paced by its own uart_bit_timer.
module uart_txrx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600,
   parameter int BIT_CLKS = calc_bit_clks(CLK_FREQ, BAUD)
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Tx_En_Sig,
   input  logic [7:0] Tx_Data,
   output logic       Tx_Done_Sig,
   output logic       Tx_Pin_Out,
   input  logic       Rx_Pin_In,
   input  logic       Rx_En_Sig,
   output logic       Rx_Done_Sig,
   output logic [7:0] Rx_Data
);

   localparam int IW = $clog2(DATA_BITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

   // ---------------- transmitter ----------------
   uart_state_t          tx_state, tx_next;
   logic [DATA_BITS-1:0] tx_shreg, tx_shreg_nxt;
   logic [IW-1:0]        tx_idx, tx_idx_nxt;
   logic                 tx_pin_nxt, tx_run, tx_tick, tx_half_unused;

   assign tx_run = (tx_state == START) || (tx_state == DATA) || (tx_state == STOP);

   uart_bit_timer #(.BIT_CLKS(BIT_CLKS)) u_tx_timer (
      .CLK       (CLK),
      .RST       (RST),
      .clr       (!tx_run),
      .en        (tx_run),
      .tick_full (tx_tick),
      .tick_half (tx_half_unused)
   );

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      tx_next      = tx_state;
      tx_shreg_nxt = tx_shreg;
      tx_idx_nxt   = tx_idx;
      case (tx_state)
         IDLE:  if (Tx_En_Sig) begin
                   tx_next      = START;
                   tx_shreg_nxt = Tx_Data;
                   tx_idx_nxt   = '0;
                end
         START: if (tx_tick) tx_next = DATA;
         DATA:  if (tx_tick) begin
                   tx_shreg_nxt = tx_shreg >> 1;
                   tx_idx_nxt   = tx_idx + IW'(1);
                   if (tx_idx == LAST_IDX) tx_next = STOP;
                end
         STOP:  if (tx_tick) tx_next = DONE;
         DONE:  tx_next = IDLE;
         default: tx_next = IDLE;
      endcase
      // Line level is registered from the next state so the pin never glitches.
      case (tx_next)
         START:   tx_pin_nxt = 1'b0;
         DATA:    tx_pin_nxt = tx_shreg_nxt[0];
         default: tx_pin_nxt = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tx_state   <= IDLE;
         tx_shreg   <= '0;
         tx_idx     <= '0;
         Tx_Pin_Out <= 1'b1;
      end else begin
         tx_state   <= tx_next;
         tx_shreg   <= tx_shreg_nxt;
         tx_idx     <= tx_idx_nxt;
         Tx_Pin_Out <= tx_pin_nxt;
      end
   end

   assign Tx_Done_Sig = (tx_state == DONE);

   // ---------------- receiver ----------------
   uart_state_t          rx_state, rx_next;
   logic [DATA_BITS-1:0] rx_shreg, rx_shreg_nxt;
   logic [IW-1:0]        rx_idx, rx_idx_nxt;
   logic                 rx_meta, rx_sync, rx_prev, rx_fall, rx_load;
   logic                 rx_run, rx_clr, rx_tick, rx_half;

   // NOTE: synchroniser flops reset to the idle line level so reset release is not seen as a start edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= Rx_Pin_In;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign rx_fall = rx_prev && !rx_sync;
   assign rx_run  = (rx_state == START) || (rx_state == DATA) || (rx_state == STOP);
   // Restarting the timer at the start-bit midpoint makes later ticks land mid-bit.
   assign rx_clr  = !rx_run || ((rx_state == START) && rx_half);

   uart_bit_timer #(.BIT_CLKS(BIT_CLKS)) u_rx_timer (
      .CLK       (CLK),
      .RST       (RST),
      .clr       (rx_clr),
      .en        (rx_run),
      .tick_full (rx_tick),
      .tick_half (rx_half)
   );

   always_comb begin
      rx_next      = rx_state;
      rx_shreg_nxt = rx_shreg;
      rx_idx_nxt   = rx_idx;
      rx_load      = 1'b0;
      case (rx_state)
         IDLE:  if (Rx_En_Sig && rx_fall) begin
                   rx_next    = START;
                   rx_idx_nxt = '0;
                end
         START: if (rx_half) rx_next = rx_sync ? IDLE : DATA;
         DATA:  if (rx_tick) begin
                   rx_shreg_nxt = {rx_sync, rx_shreg[DATA_BITS-1:1]};
                   rx_idx_nxt   = rx_idx + IW'(1);
                   if (rx_idx == LAST_IDX) rx_next = STOP;
                end
         STOP:  if (rx_tick) begin
                   rx_next = rx_sync ? DONE : IDLE;
                   rx_load = rx_sync;
                end
         DONE:  rx_next = IDLE;
         default: rx_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rx_state <= IDLE;
         rx_shreg <= '0;
         rx_idx   <= '0;
         Rx_Data  <= '0;
      end else begin
         rx_state <= rx_next;
         rx_shreg <= rx_shreg_nxt;
         rx_idx   <= rx_idx_nxt;
         if (rx_load) Rx_Data <= rx_shreg;
      end
   end

   assign Rx_Done_Sig = (rx_state == DONE);

endmodule

// File: tb/tb_uart_txrx.sv
// Directed/randomised bench for uart_txrx at 16 clocks per bit: checks the
// TX waveform and latency, loopback reception, and receiver error handling.
module tb_uart_txrx;

   localparam int BC = 16;

   logic       CLK = 1'b0;
   logic       RST;
   logic       Tx_En_Sig;
   logic [7:0] Tx_Data;
   logic       Tx_Done_Sig;
   logic       Tx_Pin_Out;
   logic       Rx_Pin_In;
   logic       Rx_En_Sig;
   logic       Rx_Done_Sig;
   logic [7:0] Rx_Data;

   logic       loop_en;
   logic       inj_pin;
   int         vectors     = 0;
   int         miscompares = 0;
   int         tx_done_cnt = 0;
   logic [7:0] rx_q[$];
   logic [7:0] last_rx;

   uart_txrx #(.BIT_CLKS(BC)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .Tx_En_Sig   (Tx_En_Sig),
      .Tx_Data     (Tx_Data),
      .Tx_Done_Sig (Tx_Done_Sig),
      .Tx_Pin_Out  (Tx_Pin_Out),
      .Rx_Pin_In   (Rx_Pin_In),
      .Rx_En_Sig   (Rx_En_Sig),
      .Rx_Done_Sig (Rx_Done_Sig),
      .Rx_Data     (Rx_Data)
   );

   assign Rx_Pin_In = loop_en ? Tx_Pin_Out : inj_pin;

   always #5 CLK = ~CLK;

   // Each Done pulse is one cycle wide, so each is seen at exactly one falling edge.
   always @(negedge CLK) begin
      if (Rx_Done_Sig) rx_q.push_back(Rx_Data);
      if (Tx_Done_Sig) tx_done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Sends one byte through the TX. The edge that captures Done high is
   // 10*BC+1 edges after the edge that sampled the enable.
   task automatic tx_frame(input logic [7:0] b);
      logic [9:0] frame;
      int         c;
      int         j;
      bit         done;
      frame     = {1'b1, b, 1'b0};
      Tx_Data   = b;
      Tx_En_Sig = 1'b1;
      c         = 0;
      done      = 1'b0;
      while (!done && c < 20 * BC) begin
         @(negedge CLK);
         c++;
         j = c - 1;
         if (j == BC) Tx_Data = ~b;
         if (Tx_Done_Sig) done = 1'b1;
         else if ((j % BC) == BC / 2 && (j / BC) < 10)
            check($sformatf("tx bit%0d of %02h", j / BC, b), 32'(Tx_Pin_Out), 32'(frame[j / BC]));
      end
      Tx_En_Sig = 1'b0;
      check($sformatf("tx done seen %02h", b), 32'(done), 32'd1);
      check($sformatf("tx latency %02h", b), c, 10 * BC + 1);
      @(negedge CLK);
   endtask

   task automatic inject(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         inj_pin = frame[i];
         repeat (BC) @(negedge CLK);
      end
      inj_pin = 1'b1;
      repeat (2 * BC) @(negedge CLK);
   endtask

   task automatic rx_expect(input string tag, input logic [7:0] b);
      check({tag, " rx count"}, rx_q.size(), 1);
      if (rx_q.size() > 0) check({tag, " rx byte"}, 32'(rx_q[0]), 32'(b));
      rx_q.delete();
      last_rx = b;
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] seq[3];
      int         n0;

      RST       = 1'b1;
      Tx_En_Sig = 1'b1;
      Tx_Data   = 8'hC3;
      Rx_En_Sig = 1'b1;
      loop_en   = 1'b1;
      inj_pin   = 1'b1;
      last_rx   = 8'h00;

      // Reset: outputs pinned even with a send request pending.
      repeat (50) begin
         @(negedge CLK);
         check("reset outputs", 32'({Tx_Pin_Out, Tx_Done_Sig, Rx_Done_Sig, Rx_Data}), 32'h400);
      end
      Tx_En_Sig = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      repeat (5) @(negedge CLK);

      // Single loopback frame.
      n0 = tx_done_cnt;
      tx_frame(8'h2E);
      repeat (4) @(negedge CLK);
      check("single tx pulses", tx_done_cnt - n0, 1);
      rx_expect("single", 8'h2E);

      // Back-to-back frames with enable dropped for one cycle on Done.
      seq = '{8'h2E, 8'h3F, 8'hDD};
      n0  = tx_done_cnt;
      for (int i = 0; i < 3; i++) tx_frame(seq[i]);
      repeat (4) @(negedge CLK);
      check("b2b tx pulses", tx_done_cnt - n0, 3);
      check("b2b rx count", rx_q.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < rx_q.size()) check($sformatf("b2b rx byte%0d", i), 32'(rx_q[i]), 32'(seq[i]));
      rx_q.delete();
      last_rx = seq[2];

      // Random loopback bytes.
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom);
         tx_frame(b);
         repeat (4) @(negedge CLK);
         rx_expect($sformatf("rand%0d", i), b);
      end

      // False start: short low glitch must not produce a byte.
      loop_en = 1'b0;
      inj_pin = 1'b0;
      repeat (4) @(negedge CLK);
      inj_pin = 1'b1;
      repeat (3 * BC) @(negedge CLK);
      check("glitch rx count", rx_q.size(), 0);
      check("glitch rx data held", 32'(Rx_Data), 32'(last_rx));
      inject(8'h55, 1'b1);
      rx_expect("after glitch", 8'h55);

      // Framing error: stop bit low, byte discarded.
      inject(8'hA5, 1'b0);
      check("framing rx count", rx_q.size(), 0);
      check("framing rx data held", 32'(Rx_Data), 32'(last_rx));
      b = 8'($urandom);
      inject(b, 1'b1);
      rx_expect("after framing", b);

      // Receiver disabled: frame ignored.
      Rx_En_Sig = 1'b0;
      inject(8'h0F, 1'b1);
      check("disabled rx count", rx_q.size(), 0);
      Rx_En_Sig = 1'b1;

      // Mid-frame reset during data bit 4 (forced to 0 so the jump to 1 is visible).
      loop_en   = 1'b1;
      b         = 8'($urandom) & 8'hEF;
      Tx_Data   = b;
      Tx_En_Sig = 1'b1;
      repeat (5 * BC + BC / 2 + 1) @(negedge CLK);
      check("pre-reset pin", 32'(Tx_Pin_Out), 32'd0);
      RST = 1'b1;
      #1;
      check("reset pin", 32'(Tx_Pin_Out), 32'd1);
      check("reset tx done", 32'(Tx_Done_Sig), 32'd0);
      check("reset rx data", 32'(Rx_Data), 32'd0);
      Tx_En_Sig = 1'b0;
      repeat (10) @(negedge CLK);
      RST = 1'b0;
      n0  = tx_done_cnt;
      repeat (12 * BC) @(negedge CLK);
      check("aborted tx pulses", tx_done_cnt - n0, 0);
      check("aborted rx count", rx_q.size(), 0);
      tx_frame(8'h3F);
      repeat (4) @(negedge CLK);
      rx_expect("post reset", 8'h3F);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
